// File: rtl/field_line_clear.sv
// field_line_clear
//
// This is the row-clear stage that runs after a piece locks. It takes the merged
// playfield and scans it one row per cycle, starting at the bottom row. When a
// row is completely full, the block deletes it. Every row above the deleted row
// moves down by one, and a zero row is inserted at the top. The same row is then
// tested again, so stacked full rows are handled. At the end the block returns
// the compacted field, the number of rows removed, and a saturating running total.
//
// Ports:
//   clk           rising-edge system clock
//   rst_n         asynchronous active-low reset
//   start         request pulse, accepted only while idle
//   field_in      merged field, captured on the edge that accepts start
//   busy          high while an operation is in flight (SCAN/SHIFT/DONE)
//   done          one-cycle completion pulse
//   field_out     compacted field, held until the next done
//   lines_cleared rows removed by the last operation (0..FIELD_H)
//   total_lines   rows removed since reset, saturating at 16'hFFFF
//
// Cell (x,y) is bit y*FIELD_W + x. Row 0 is the top row.

module field_line_clear #(
  parameter int FIELD_W = 20,
  parameter int FIELD_H = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [FIELD_W*FIELD_H-1:0] field_in,
  output logic                       busy,
  output logic                       done,
  output logic [FIELD_W*FIELD_H-1:0] field_out,
  output logic [4:0]                 lines_cleared,
  output logic [15:0]                total_lines
);

  localparam int N  = FIELD_W * FIELD_H;
  localparam int RW = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    wf_q, wf_d;
  logic [RW-1:0]   r_q, r_d;
  logic [RW-1:0]   k_q, k_d;

  logic [N-1:0]    field_out_q;
  logic [4:0]      lines_q;
  logic [15:0]     total_q;

  logic [FIELD_H-1:0] row_full;
  logic               row_full_sel;
  logic [N-1:0]       wf_shift;
  logic               load_out;
  logic [16:0]        total_sum;
  logic [15:0]        total_sat;

  // Per-row "all ones" flags. The pointer r only selects one of them.
  for (genvar gi = 0; gi < FIELD_H; gi++) begin : g_full
    assign row_full[gi] = &wf_q[gi*FIELD_W +: FIELD_W];
  end

  assign row_full_sel = row_full[r_q];

  // This is the field after the row at r is deleted. Rows 1..r take the row
  // above them, row 0 becomes empty, and rows below r keep their contents.
  for (genvar gi = 0; gi < FIELD_H; gi++) begin : g_shift
    if (gi == 0) begin : g_top
      assign wf_shift[0 +: FIELD_W] = '0;
    end else begin : g_row
      assign wf_shift[gi*FIELD_W +: FIELD_W] =
        (RW'(gi) <= r_q) ? wf_q[(gi-1)*FIELD_W +: FIELD_W]
                         : wf_q[gi*FIELD_W +: FIELD_W];
    end
  end

  // The scan is finished when the top row has been tested and it is not full.
  assign load_out  = (state_q == S_SCAN) && !row_full_sel && (r_q == '0);
  assign total_sum = {1'b0, total_q} + {12'b0, k_q};
  assign total_sat = total_sum[16] ? 16'hFFFF : total_sum[15:0];

  always_comb begin
    state_d = state_q;
    wf_d    = wf_q;
    r_d     = r_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          wf_d    = field_in;
          r_d     = RW'(FIELD_H - 1);
          k_d     = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (row_full_sel) begin
          state_d = S_SHIFT;
        end else if (r_q == '0) begin
          state_d = S_DONE;
        end else begin
          r_d = r_q - 1'b1;
        end
      end
      S_SHIFT: begin
        // r is left unchanged so that the row just pulled down is re-tested.
        wf_d    = wf_shift;
        k_d     = k_q + 1'b1;
        state_d = S_SCAN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wf_q    <= '0;
      r_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      wf_q    <= wf_d;
      r_q     <= r_d;
      k_q     <= k_d;
    end
  end

  // The results are registered as the FSM enters DONE, so they become
  // visible together with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_out_q <= '0;
      lines_q     <= '0;
      total_q     <= '0;
    end else if (load_out) begin
      field_out_q <= wf_q;
      lines_q     <= k_q;
      total_q     <= total_sat;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign field_out     = field_out_q;
  assign lines_cleared = lines_q;
  assign total_lines   = total_q;

endmodule

// File: doc/field_line_clear.md
# field_line_clear

Post-lock row-clear stage for the 20x20 playfield. When a falling piece locks, the merge stage's composed field is presented here. This block scans every row bottom-up, deletes each completely filled row, and drops all rows above it down by one. It then returns the compacted field to the controller as the new background, together with the number of rows removed.

## Interface

Parameters:
- `FIELD_W`, default 20: cells per row.
- `FIELD_H`, default 20: number of rows.
- Field vector width is `FIELD_W*FIELD_H` (400). Cell (x,y) is bit `y*FIELD_W + x`. Row 0 is the top row; row `FIELD_H-1` is the bottom row.

Ports (clock and reset first):
- `clk`, input, 1: single system clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request pulse. Sampled only in IDLE.
- `field_in`, input, 400: merged field. Sampled on the edge that accepts `start`.
- `busy`, output, 1: high while a clear operation is in progress.
- `done`, output, 1: one-cycle completion pulse.
- `field_out`, output, 400: compacted field. Valid from `done` onward; held until the next `done`.
- `lines_cleared`, output, 5: rows removed by the last operation, range 0..20.
- `total_lines`, output, 16: running count of cleared rows since reset. Saturates at 16'hFFFF.

## Operation

- **Internal state:** working field register `wf` (400 bits), row pointer `r` (5 bits), clear counter `k` (5 bits), and an FSM with states IDLE, SCAN, SHIFT, DONE.
- **IDLE:**
  - If `start`=1: `wf`<=`field_in`, `r`<=`FIELD_H-1`, `k`<=0, go to SCAN.
  - If `start`=0: stay in IDLE.
- **SCAN:** test whether row `r` of `wf` is all ones.
  - Row full: go to SHIFT. `r` is unchanged.
  - Row not full and `r`==0: go to DONE.
  - Row not full and `r`!=0: `r`<=`r`-1, stay in SCAN.
- **SHIFT:** a single cycle that applies the following together, then returns to SCAN with the same `r` (the row is re-tested, so stacked full rows are handled):
  - for every row j with 1<=j<=`r`, row j of `wf` <= row j-1;
  - row 0 <= 0;
  - rows below `r` are unchanged;
  - `k`<=`k`+1.
- **DONE:** a single cycle, then IDLE. On entry to DONE (registered together):
  - `field_out`<=`wf`;
  - `lines_cleared`<=`k`;
  - `total_lines`<=min(`total_lines`+`k`, 65535), with the add computed 17 bits wide before saturation.
- **Outputs:**
  - `busy`=1 in SCAN, SHIFT and DONE.
  - `done`=1 only in DONE.
  - Both are decoded from the registered state.
- **Start rules:**
  - `start` while `busy`=1 is ignored and is not queued.
  - `start` in the same cycle as `done` is also ignored.
  - `field_in` changes while busy have no effect.
- **Termination:** every SHIFT writes a zero row at the top, so a fully-set field (k=20) still terminates.

## Timing

- **Latency:** `start` is accepted at edge E0. `done` is high for exactly the cycle after edge E0+20+2k. Examples:
  - k=0: done after edge E0+20.
  - k=4: done after edge E0+28.
  - k=20 (maximum): done after edge E0+60.
- **Back-to-back:** the earliest next accepted `start` is at the edge ending the DONE cycle +1, i.e. IDLE must be observed for one cycle.
- **Reset values** (`rst_n`=0, asynchronous, any time including mid-operation):
  - state=IDLE;
  - `busy`=0, `done`=0;
  - `field_out`=0, `lines_cleared`=0, `total_lines`=0;
  - `wf`=0, `r`=0, `k`=0.
  - An operation interrupted by reset produces no `done` and no output update.

## Test plan

- **Empty field:** `field_in`=0, pulse `start`. Required: `done` after 20 edges, `field_out`=0, `lines_cleared`=0, `total_lines`=0, `busy` high for 21 cycles.
- **Single bottom row:** row 19 all ones, plus cell (3,18)=1. Required: `done` after 22 edges, `lines_cleared`=1, `field_out` has only bit 19*20+3 set, `total_lines`=1.
- **Non-adjacent rows with markers:** rows 17 and 19 full, cell (0,18)=1, cell (5,10)=1. Required: `lines_cleared`=2, `field_out` has only cell (0,19) and cell (5,12) set, latency 24 edges.
- **Full field:** all 400 bits=1. Required: `done` after 60 edges, `field_out`=0, `lines_cleared`=20.
- **Start while busy:** pulse `start` again 5 cycles into an operation with a different `field_in`. Required: ignored, only one `done`, result matches the first field. Repeating the first test 3 more times accumulates `total_lines`.
- **Reset mid-operation:** assert `rst_n`=0 during SHIFT of the full-field case. Required: `busy`=0 immediately (asynchronous), all outputs 0, no `done`. After release, a new `start` with the single-bottom-row field completes normally with `total_lines`=1.
